// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared types and constants for the instruction-memory access controller
// Contents:
//   im_state_t          controller phase: S_LOAD (loader owns memory) / S_RUN (core runs)
//   NOP_INSTR           instruction returned whenever no valid fetch data exists
//   NMEM_DEF/AW_DEF     default memory depth and word-address width
//   DBG_MAX_DEF         default cap on consecutive debug grants while fetch waits
package mips_pkg;

   typedef enum logic {
      S_LOAD = 1'b0,
      S_RUN  = 1'b1
   } im_state_t;

   localparam logic [31:0] NOP_INSTR   = 32'h0000_0000;
   localparam int          NMEM_DEF    = 128;
   localparam int          AW_DEF      = 7;
   localparam int          DBG_MAX_DEF = 4;

endpackage

// File: rtl/im_rr_grant.sv
// rtl/im_rr_grant.sv - fetch/debug grant arbiter with debug streak limiter
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   run                 arbitration enabled (controller in S_RUN)
//   fetch_req           IF stage requests an instruction this cycle
//   dbg_req             debug read request
//   dbg_pend            debug ack cycle in progress; debug request ignored
//   fetch_gnt, dbg_gnt  combinational one-hot (or none) grants
module im_rr_grant
   import mips_pkg::*;
#(
   parameter int DBG_MAX = DBG_MAX_DEF
) (
   input  logic clk,
   input  logic reset_n,
   input  logic run,
   input  logic fetch_req,
   input  logic dbg_req,
   input  logic dbg_pend,
   output logic fetch_gnt,
   output logic dbg_gnt
);

   localparam int SW = $clog2(DBG_MAX + 1);

   logic [SW-1:0] streak;

   // Debug normally wins, but only DBG_MAX times in a row while fetch is waiting.
   assign dbg_gnt   = run & dbg_req & ~dbg_pend & ((streak < SW'(DBG_MAX)) | ~fetch_req);
   assign fetch_gnt = run & fetch_req & ~dbg_gnt;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         streak <= '0;
      end else if (!fetch_req || fetch_gnt) begin
         streak <= '0;
      end else if (dbg_gnt) begin
         streak <= streak + SW'(1);
      end
   end

endmodule

// File: rtl/im_access_ctrl.sv
// rtl/im_access_ctrl.sv - instruction-memory load sequencer and fetch/debug access arbiter
// Ports:
//   clk, reset_n                      clock, asynchronous active-low reset
//   ld_valid/ld_ready/ld_data/ld_last loader word stream (load phase only)
//   reload_req                        pulse in run phase: return to load phase
//   fetch_pc/fetch_req                IF-stage byte PC and request
//   fetch_data/fetch_stall/fetch_fault instruction to IF/ID, hold-PC, out-of-range PC
//   dbg_req/dbg_addr                  debug read request (held until ack) and word address
//   dbg_ack/dbg_rdata                 one-cycle ack pulse with registered read data
//   im_addr/im_wdata/im_we/im_rdata   memory port (async read, sync write)
//   cpu_run                           pipeline enable
//   load_count/load_err               words written by last load, sticky overflow flag
module im_access_ctrl
   import mips_pkg::*;
#(
   parameter int NMEM    = NMEM_DEF,
   parameter int AW      = AW_DEF,
   parameter int DBG_MAX = DBG_MAX_DEF
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          ld_valid,
   output logic          ld_ready,
   input  logic [31:0]   ld_data,
   input  logic          ld_last,
   input  logic          reload_req,
   input  logic [31:0]   fetch_pc,
   input  logic          fetch_req,
   output logic [31:0]   fetch_data,
   output logic          fetch_stall,
   output logic          fetch_fault,
   input  logic          dbg_req,
   input  logic [AW-1:0] dbg_addr,
   output logic          dbg_ack,
   output logic [31:0]   dbg_rdata,
   output logic [AW-1:0] im_addr,
   output logic [31:0]   im_wdata,
   output logic          im_we,
   input  logic [31:0]   im_rdata,
   output logic          cpu_run,
   output logic [AW:0]   load_count,
   output logic          load_err
);

   localparam logic [AW-1:0] LAST_PTR = AW'(NMEM - 1);

   im_state_t     state;
   logic [AW-1:0] wr_ptr;
   logic          accept;
   logic          fetch_gnt;
   logic          dbg_gnt;
   logic          fault;
   logic [AW-1:0] fetch_addr;

   // ld_ready is registered and only high in S_LOAD, so it also gates the write.
   assign accept     = ld_valid & ld_ready;
   assign im_we      = accept;
   assign im_wdata   = ld_data;
   assign fetch_addr = fetch_pc[AW+1:2];
   assign fault      = (fetch_pc[31:AW+2] != '0) | (fetch_pc[1:0] != 2'b00);

   always_comb begin
      im_addr = fetch_addr;
      if (state == S_LOAD) begin
         im_addr = wr_ptr;
      end else if (dbg_gnt) begin
         im_addr = dbg_addr;
      end
   end

   // A faulting fetch is still a grant: no stall, but a NOP is delivered.
   assign fetch_data  = (fetch_gnt & ~fault) ? im_rdata : NOP_INSTR;
   assign fetch_stall = fetch_req & ~fetch_gnt;
   assign fetch_fault = fetch_gnt & fault;

   im_rr_grant #(
      .DBG_MAX (DBG_MAX)
   ) u_grant (
      .clk       (clk),
      .reset_n   (reset_n),
      .run       (state == S_RUN),
      .fetch_req (fetch_req),
      .dbg_req   (dbg_req),
      .dbg_pend  (dbg_ack),
      .fetch_gnt (fetch_gnt),
      .dbg_gnt   (dbg_gnt)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= S_LOAD;
         wr_ptr     <= '0;
         ld_ready   <= 1'b0;
         cpu_run    <= 1'b0;
         dbg_ack    <= 1'b0;
         dbg_rdata  <= '0;
         load_count <= '0;
         load_err   <= 1'b0;
      end else begin
         // A debug grant in the reload cycle still completes its ack.
         dbg_ack <= dbg_gnt;
         if (dbg_gnt) begin
            dbg_rdata <= im_rdata;
         end

         if (state == S_LOAD) begin
            ld_ready <= 1'b1;
            if (accept) begin
               wr_ptr     <= wr_ptr + AW'(1);
               load_count <= {1'b0, wr_ptr} + (AW+1)'(1);
               // Filling the last entry without ld_last is an overflow: stop, never wrap.
               if (ld_last || wr_ptr == LAST_PTR) begin
                  state    <= S_RUN;
                  ld_ready <= 1'b0;
                  cpu_run  <= 1'b1;
                  if (!ld_last) begin
                     load_err <= 1'b1;
                  end
               end
            end
         end else if (reload_req) begin
            state    <= S_LOAD;
            wr_ptr   <= '0;
            load_err <= 1'b0;
            ld_ready <= 1'b1;
            cpu_run  <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_im_access_ctrl.sv
// tb/tb_im_access_ctrl.sv - self-checking bench for im_access_ctrl against a behavioural model
module tb_im_access_ctrl;

   localparam int NMEM    = 128;
   localparam int AW      = 7;
   localparam int DBG_MAX = 4;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          ld_valid, ld_ready, ld_last, reload_req;
   logic [31:0]   ld_data;
   logic [31:0]   fetch_pc, fetch_data;
   logic          fetch_req, fetch_stall, fetch_fault;
   logic          dbg_req, dbg_ack;
   logic [AW-1:0] dbg_addr, im_addr;
   logic [31:0]   dbg_rdata, im_wdata, im_rdata;
   logic          im_we, cpu_run, load_err;
   logic [AW:0]   load_count;

   always #5 clk = ~clk;

   im_access_ctrl #(.NMEM(NMEM), .AW(AW), .DBG_MAX(DBG_MAX)) dut (
      .clk(clk), .reset_n(reset_n),
      .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data), .ld_last(ld_last),
      .reload_req(reload_req),
      .fetch_pc(fetch_pc), .fetch_req(fetch_req), .fetch_data(fetch_data),
      .fetch_stall(fetch_stall), .fetch_fault(fetch_fault),
      .dbg_req(dbg_req), .dbg_addr(dbg_addr), .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
      .im_addr(im_addr), .im_wdata(im_wdata), .im_we(im_we), .im_rdata(im_rdata),
      .cpu_run(cpu_run), .load_count(load_count), .load_err(load_err)
   );

   // Instruction memory: asynchronous read, synchronous write.
   logic [31:0] mem [NMEM];
   logic        mem_clr = 1'b1;
   always @(posedge clk) begin
      if (mem_clr) begin
         for (int i = 0; i < NMEM; i++) mem[i] <= 32'h0;
      end else if (im_we) begin
         mem[im_addr] <= im_wdata;
      end
   end
   assign im_rdata = mem[im_addr];

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model state.
   logic [31:0] ref_mem [NMEM];
   bit          m_run, m_rdy, m_err, m_ack, m_dgnt, m_fgnt, m_acc, obs_we;
   int          m_wr, m_cnt, m_streak;
   logic [31:0] m_rdata;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_run = 0; m_rdy = 0; m_err = 0; m_ack = 0;
      m_wr = 0; m_cnt = 0; m_streak = 0; m_rdata = 32'h0;
   endtask

   // One clock cycle: predict, check mid-cycle, clock, update the model.
   task automatic cycle();
      bit          fault;
      int          faddr;
      logic [31:0] e_fdata;
      if (!reset_n) model_reset();
      m_acc  = m_rdy && ld_valid;
      m_dgnt = m_run && dbg_req && !m_ack && (m_streak < DBG_MAX || !fetch_req);
      m_fgnt = m_run && fetch_req && !m_dgnt;
      faddr  = (fetch_pc / 4) % NMEM;
      fault  = (fetch_pc >= 32'(NMEM * 4)) || (fetch_pc % 4 != 0);
      e_fdata = (m_fgnt && !fault) ? ref_mem[faddr] : 32'h0;
      #2;
      obs_we = im_we;
      chk("ld_ready",    32'(ld_ready),    32'(m_rdy));
      chk("im_we",       32'(im_we),       32'(m_acc));
      chk("cpu_run",     32'(cpu_run),     32'(m_run));
      chk("fetch_stall", 32'(fetch_stall), 32'(fetch_req && !m_fgnt));
      chk("fetch_fault", 32'(fetch_fault), 32'(m_fgnt && fault));
      chk("fetch_data",  fetch_data,       e_fdata);
      chk("dbg_ack",     32'(dbg_ack),     32'(m_ack));
      chk("dbg_rdata",   dbg_rdata,        m_rdata);
      chk("load_count",  32'(load_count),  m_cnt);
      chk("load_err",    32'(load_err),    32'(m_err));
      if (m_acc) begin
         chk("wr_addr",  32'(im_addr), m_wr);
         chk("wr_data",  im_wdata,     ld_data);
      end else if (m_dgnt) begin
         chk("dbg_addr", 32'(im_addr), 32'(dbg_addr));
      end else if (m_fgnt) begin
         chk("fetch_addr", 32'(im_addr), faddr);
      end
      @(posedge clk);
      #1;
      if (reset_n) begin
         if (m_acc) begin
            ref_mem[m_wr] = ld_data;
            m_cnt = m_wr + 1;
            if (ld_last) m_run = 1;
            else if (m_wr == NMEM - 1) begin
               m_err = 1;
               m_run = 1;
            end
            m_wr++;
         end else if (m_run && reload_req) begin
            m_run = 0;
            m_wr  = 0;
            m_err = 0;
         end
         if (m_dgnt) m_rdata = ref_mem[dbg_addr];
         m_ack = m_dgnt;
         if (!fetch_req || m_fgnt) m_streak = 0;
         else if (m_dgnt) m_streak++;
         m_rdy = !m_run;
      end
   endtask

   // Stream n words; returns the number of writes the DUT actually made.
   task automatic load(input int n, input bit use_last, input bit seq_data, output int writes);
      int i = 0;
      writes = 0;
      ld_valid = 1;
      for (int c = 0; c < n + 4 && i < n; c++) begin
         ld_data = seq_data ? 32'h8C10_0000 + i : $urandom;
         ld_last = use_last && (i == n - 1);
         cycle();
         if (obs_we) writes++;
         if (m_acc) i++;
      end
      for (int c = 0; c < 3; c++) begin
         ld_data = $urandom;
         ld_last = 0;
         cycle();
         if (obs_we) writes++;
      end
      ld_valid = 0;
      ld_last  = 0;
   endtask

   task automatic run_traffic(input int n, input int dbg_pct, input bit always_fetch);
      bit pend = 0;
      for (int c = 0; c < n; c++) begin
         fetch_req = always_fetch || ($urandom_range(0, 3) != 0);
         fetch_pc  = ($urandom_range(0, 7) == 0) ? $urandom : {23'b0, 7'($urandom), 2'b00};
         if (m_ack) begin
            dbg_req = ($urandom_range(0, 5) == 0);
         end else begin
            if (!pend && $urandom_range(0, 99) < dbg_pct) begin
               pend = 1;
               dbg_addr = 7'($urandom);
            end
            dbg_req = pend;
         end
         cycle();
         if (m_dgnt) pend = 0;
      end
      dbg_req   = 0;
      fetch_req = 0;
   endtask

   initial begin
      int wr;
      reset_n = 0; ld_valid = 0; ld_last = 0; ld_data = 0; reload_req = 0;
      fetch_pc = 0; fetch_req = 0; dbg_req = 0; dbg_addr = 0;
      for (int i = 0; i < NMEM; i++) ref_mem[i] = 32'h0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      mem_clr = 0;
      chk("rst_ld_ready", 32'(ld_ready), 0);
      chk("rst_cpu_run",  32'(cpu_run), 0);
      chk("rst_im_we",    32'(im_we), 0);
      chk("rst_dbg_ack",  32'(dbg_ack), 0);
      chk("rst_dbg_rdata", dbg_rdata, 0);
      chk("rst_load_count", 32'(load_count), 0);
      chk("rst_load_err", 32'(load_err), 0);
      reset_n = 1;
      cycle();

      // 21-word program with ld_last on the final word.
      load(21, 1, 1, wr);
      chk("l21_writes", wr, 21);
      chk("l21_count", 32'(load_count), 21);
      chk("l21_run", 32'(cpu_run), 1);
      chk("l21_err", 32'(load_err), 0);

      fetch_req = 1; fetch_pc = 32'h20;
      #2;
      chk("pc20_addr", 32'(im_addr), 8);
      chk("pc20_data", fetch_data, 32'h8C10_0008);
      chk("pc20_stall", 32'(fetch_stall), 0);
      cycle();
      fetch_pc = 32'h200;
      #2;
      chk("pc200_fault", 32'(fetch_fault), 1);
      chk("pc200_data", fetch_data, 0);
      chk("pc200_stall", 32'(fetch_stall), 0);
      cycle();
      fetch_req = 0;

      run_traffic(60, 100, 1);
      run_traffic(200, 40, 0);

      // Reload coinciding with a debug grant.
      cycle(); cycle();
      dbg_req = 1; dbg_addr = 7'd5; fetch_req = 1; reload_req = 1;
      cycle();
      reload_req = 0; dbg_req = 0; fetch_req = 0;
      chk("reload_ack", 32'(dbg_ack), 1);
      chk("reload_rdata", dbg_rdata, 32'h8C10_0005);
      chk("reload_run", 32'(cpu_run), 0);
      cycle();
      ld_valid = 1; ld_data = $urandom; ld_last = 0;
      #2;
      chk("reload_addr0", 32'(im_addr), 0);
      chk("reload_we", 32'(im_we), 1);
      cycle();
      load(4, 1, 0, wr);
      run_traffic(100, 50, 0);

      // Overflow: 129 words, no ld_last.
      reload_req = 1;
      cycle();
      reload_req = 0;
      load(129, 0, 0, wr);
      chk("ovf_writes", wr, 128);
      chk("ovf_err", 32'(load_err), 1);
      chk("ovf_count", 32'(load_count), 128);
      chk("ovf_run", 32'(cpu_run), 1);
      run_traffic(150, 40, 0);

      // Reset in the middle of a load.
      reload_req = 1;
      cycle();
      reload_req = 0;
      load(5, 0, 0, wr);
      ld_valid = 1;
      reset_n = 0;
      #1;
      chk("mid_rst_ld_ready", 32'(ld_ready), 0);
      chk("mid_rst_cpu_run", 32'(cpu_run), 0);
      chk("mid_rst_im_we", 32'(im_we), 0);
      chk("mid_rst_count", 32'(load_count), 0);
      chk("mid_rst_err", 32'(load_err), 0);
      #1;
      cycle(); cycle();
      reset_n = 1;
      load(10, 1, 0, wr);
      chk("post_rst_count", 32'(load_count), 10);
      run_traffic(150, 40, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
